// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button press decoder.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESSED = 2'd2,
        DISARM  = 2'd3
    } state_t;

    // 100 MHz board clock: 10 ms debounce, 0.5 s first repeat, 0.1 s later repeats.
    localparam int DEF_DEB_CYCLES    = 1_000_000;
    localparam int DEF_REPEAT_DELAY  = 50_000_000;
    localparam int DEF_REPEAT_PERIOD = 10_000_000;
    localparam int DEF_CNT_W         = 31;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous active-low clear, for any raw board input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/btn_press_decoder.sv
// Debounces a raw button into press/release pulses and a held level.
// Define BTN_AUTO_REPEAT_EN to add auto-repeat press pulses while the button stays down.
module btn_press_decoder
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    output logic       press,
    output logic       release_p,
    output logic       held,
    output logic [1:0] state_dbg
);

    if (DEB_CYCLES < 1 || (DEB_CYCLES >> CNT_W) != 0) begin : g_bad_deb
        $error("DEB_CYCLES must be >= 1 and fit in CNT_W bits");
    end
    if (REPEAT_DELAY < 1 || (REPEAT_DELAY >> CNT_W) != 0) begin : g_bad_delay
        $error("REPEAT_DELAY must be >= 1 and fit in CNT_W bits");
    end
    if (REPEAT_PERIOD < 1 || (REPEAT_PERIOD >> CNT_W) != 0) begin : g_bad_period
        $error("REPEAT_PERIOD must be >= 1 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_C   = CNT_W'(DEB_CYCLES);

    logic             in_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, release_d, held_d;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (in),
        .q     (in_s)
    );

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_M1  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_M1 = CNT_W'(REPEAT_PERIOD - 1);

    // rep_first selects the long initial delay until the first repeat has fired.
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             rep_first_q, rep_first_d;
    logic [CNT_W-1:0] rep_last;

    assign rep_last = rep_first_q ? DELAY_M1 : PERIOD_M1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt_q      <= '0;
            rep_first_q <= 1'b0;
        end else begin
            rcnt_q      <= rcnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press     <= 1'b0;
            release_p <= 1'b0;
            held      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press     <= press_d;
            release_p <= release_d;
            held      <= held_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        held_d    = held;
`ifdef BTN_AUTO_REPEAT_EN
        rcnt_d      = rcnt_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_s) begin
                    state_d = ARM;
                    cnt_d   = CNT_ONE;
                end
            end
            ARM: begin
                if (!in_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_C) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    held_d  = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                    rcnt_d      = '0;
                    rep_first_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!in_s) begin
                    state_d = DISARM;
                    cnt_d   = CNT_ONE;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (rcnt_q == rep_last) begin
                        press_d     = 1'b1;
                        rcnt_d      = '0;
                        rep_first_d = 1'b0;
                    end else if (rcnt_q != '1) begin
                        rcnt_d = rcnt_q + CNT_ONE;
                    end
`endif
                end
            end
            DISARM: begin
                // A bounce back high cancels the release and restarts the repeat schedule.
                if (in_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    rcnt_d      = '0;
                    rep_first_d = 1'b1;
`endif
                end else if (cnt_q == DEB_C) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_btn_press_decoder.sv
// Self-checking bench for btn_press_decoder with short debounce/repeat parameters.
module tb_btn_press_decoder;
  import btn_pkg::*;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int CW  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in;
  logic       press;
  logic       release_p;
  logic       held;
  logic [1:0] state_dbg;

  btn_press_decoder #(
    .DEB_CYCLES    (DEB),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP),
    .CNT_W         (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .press     (press),
    .release_p (release_p),
    .held      (held),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic in;
    logic press;
    logic rel;
    logic held;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string name, input int cyc, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
  endtask

  // Drive one cycle of input, queue its expected outputs, compare just after the edge.
  task automatic step(input string name, input int cyc, input logic in_v, input logic [2:0] e);
    in = in_v;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check(name, cyc, {press, release_p, held}, exp_q.pop_front());
  endtask

  task automatic run_vecs(input string name, input int base);
    foreach (vecs[i]) step(name, base + i, vecs[i].in, {vecs[i].press, vecs[i].rel, vecs[i].held});
    vecs.delete();
  endtask

  function automatic void add(input logic i_v, input logic p, input logic r, input logic h);
    vecs.push_back('{i_v, p, r, h});
  endfunction

  function automatic logic exp_press_long(input int c);
    logic p;
    p = (c == 6);
`ifdef BTN_AUTO_REPEAT_EN
    if (c >= RD + 6 && ((c - RD - 6) % RP) == 0) p = 1'b1;
`endif
    return p;
  endfunction

  initial begin
    rst_n = 1'b0;
    in    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 0, {press, release_p, held}, 3'b000);
    check("reset_state", 0, {1'b0, state_dbg}, {1'b0, 2'(IDLE)});
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) step("idle", c, 1'b0, 3'b000);

    // Glitch shorter than the debounce window.
    for (int c = 0; c < 13; c++) add(c < 3, 1'b0, 1'b0, 1'b0);
    run_vecs("glitch", 0);

    // Long clean press.
    for (int c = 0; c < 60; c++) add(1'b1, exp_press_long(c), 1'b0, c >= 6);
    run_vecs("clean_press", 0);
    check("pressed_state", 59, {1'b0, state_dbg}, {1'b0, 2'(PRESSED)});

    // Bouncy release: 0,0,1 then steady 0 from cycle 63.
    for (int c = 60; c < 73; c++) add(c == 62, 1'b0, c == 69, c < 69);
    run_vecs("bouncy_release", 60);

    // Reset asserted mid-press with the button still down.
    for (int c = 0; c < 10; c++) step("rst_mid", c, 1'b1, {c == 6, 1'b0, c >= 6});
    rst_n = 1'b0;
    #1;
    check("async_clear", 10, {press, release_p, held}, 3'b000);
    check("async_state", 10, {1'b0, state_dbg}, {1'b0, 2'(IDLE)});
    for (int c = 10; c < 15; c++) step("rst_low", c, 1'b1, 3'b000);
    rst_n = 1'b1;
    for (int c = 15; c < 31; c++) step("rst_repress", c, 1'b1, {c == 21, 1'b0, c >= 21});
    for (int c = 31; c < 41; c++) step("rst_release", c, 1'b0, {1'b0, c == 37, c < 37});

    // Toggle every 5 cycles: events alternate, one cycle each, 5 cycles apart.
    for (int c = 0; c < 52; c++)
      add(c < 40 && (c % 10) < 5,
          c < 40 && (c % 10) == 6,
          c >= 11 && c <= 41 && (c % 10) == 1,
          c >= 6 && c < 41 && ((c % 10) >= 6 || (c % 10) == 0));
    run_vecs("toggle", 0);

    check("scoreboard_drained", 0, 3'(exp_q.size()), 3'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
